// File: rtl/mips_mctrl_pkg.sv
// mips_mctrl_pkg: opcode/funct constants, ALU control codes, controller states and decode classes
package mips_mctrl_pkg;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_SLT    = 6'b101010;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUBU = 3'b001,
    ALU_OR   = 3'b010,
    ALU_ADDI = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_LUI  = 3'b101
  } alu_ctr_e;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MWB   = 4'd4,
    S_MW    = 4'd5,
    S_EXE   = 4'd6,
    S_AWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_e;
  typedef struct packed {
    logic load;
    logic store;
    logic ralu;
    logic ialu;
    logic beq;
    logic bltzal;
    logic jmp;
    logic jal;
    logic jr;
    logic bad;
  } iclass_t;
endpackage

// File: rtl/mips_idec.sv
// mips_idec: combinational op/funct/rt decode into a one-hot instruction class and the EXE ALU code
module mips_idec
  import mips_mctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output iclass_t    cls,
  output alu_ctr_e   alu
);
  logic rtype;
  assign rtype = op == OP_RTYPE;
  always_comb begin
    cls        = '0;
    cls.load   = op == OP_LW || op == OP_LB;
    cls.store  = op == OP_SW || op == OP_SB;
    cls.ralu   = rtype && (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT);
    cls.ialu   = op == OP_ORI || op == OP_LUI || op == OP_ADDI || op == OP_ADDIU;
    cls.beq    = op == OP_BEQ;
    cls.bltzal = op == OP_REGIMM && rt == RT_BLTZAL;
    cls.jmp    = op == OP_J;
    cls.jal    = op == OP_JAL;
    cls.jr     = rtype && funct == FN_JR;
    cls.bad    = ~|cls;
    alu = (rtype && funct == FN_SUBU) ? ALU_SUBU :
          (rtype && funct == FN_SLT)  ? ALU_SLT  :
          op == OP_ORI                ? ALU_OR   :
          op == OP_ADDI               ? ALU_ADDI :
          op == OP_LUI                ? ALU_LUI  : ALU_ADD;
  end
endmodule

// File: rtl/mips_mctrl.sv
// mips_mctrl: multi-cycle MIPS Moore control FSM with registered instruction fields
module mips_mctrl
  import mips_mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       overflow,
  input  logic       bltzal_sel,
  output logic [2:0] ALUCtr,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic       ExtOp,
  output logic       MemByte,
  output logic       ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] PCSrc,
  output logic       illegal
);
  state_e     state, nxt;
  logic [5:0] op_q, funct_q;
  logic [4:0] rt_q;
  iclass_t    cls;
  alu_ctr_e   alu;
  logic       dcd, byte_q, awb;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, ill, ext_op, src_b, mem_byte;
  logic [2:0] alu_ctr;
  logic [1:0] reg_dst, mem_to_reg, pc_src;
  assign dcd    = state == S_DCD;
  assign awb    = state == S_AWB;
  assign byte_q = op_q == OP_LB || op_q == OP_SB;
  mips_idec u_idec (
    .op   (dcd ? op : op_q),
    .funct(dcd ? funct : funct_q),
    .rt   (dcd ? rt : rt_q),
    .cls  (cls),
    .alu  (alu)
  );
  always_ff @(posedge clk) begin
    state <= rst_n ? nxt : S_FETCH;
    if (dcd) begin
      op_q    <= op;
      funct_q <= funct;
      rt_q    <= rt;
    end
  end
  always_comb begin
    nxt        = S_FETCH;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ill        = 1'b0;
    ext_op     = 1'b0;
    src_b      = 1'b0;
    mem_byte   = 1'b0;
    alu_ctr    = ALU_ADD;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_src     = 2'b00;
    case (state)
      S_FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
        nxt   = S_DCD;
      end
      S_DCD: begin
        ill = cls.bad;
        nxt = (cls.load || cls.store)          ? S_MA  :
              (cls.ralu || cls.ialu)           ? S_EXE :
              (cls.beq || cls.bltzal)          ? S_BR  :
              (cls.jmp || cls.jal || cls.jr)   ? S_JMP : S_FETCH;
      end
      S_MA: begin
        alu_ctr = ALU_ADD;
        src_b   = 1'b1;
        ext_op  = 1'b1;
        nxt     = cls.load ? S_MR : S_MW;
      end
      S_MR: begin
        mem_byte = byte_q;
        nxt      = S_MWB;
      end
      S_MWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
        mem_byte   = byte_q;
      end
      S_MW: begin
        mem_wr   = 1'b1;
        mem_byte = byte_q;
      end
      S_EXE, S_AWB: begin
        alu_ctr = alu;
        src_b   = !cls.ralu;
        ext_op  = op_q != OP_ORI;
        reg_wr  = awb && !(op_q == OP_ADDI && overflow);
        reg_dst = (awb && cls.ralu) ? 2'b01 : 2'b00;
        nxt     = awb ? S_FETCH : S_AWB;
      end
      S_BR: begin
        alu_ctr    = ALU_SUBU;
        pc_src     = 2'b01;
        pc_wr      = cls.beq ? zero : bltzal_sel;
        reg_wr     = cls.bltzal;
        reg_dst    = cls.bltzal ? 2'b10 : 2'b00;
        mem_to_reg = cls.bltzal ? 2'b10 : 2'b00;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        pc_src     = cls.jr ? 2'b11 : 2'b10;
        reg_wr     = cls.jal;
        reg_dst    = cls.jal ? 2'b10 : 2'b00;
        mem_to_reg = cls.jal ? 2'b10 : 2'b00;
      end
      default: nxt = S_FETCH;
    endcase
  end
  assign PCWr     = rst_n & pc_wr;
  assign IRWr     = rst_n & ir_wr;
  assign RegWr    = rst_n & reg_wr;
  assign MemWr    = rst_n & mem_wr;
  assign illegal  = rst_n & ill;
  assign ExtOp    = rst_n & ext_op;
  assign ALUSrcB  = rst_n & src_b;
  assign MemByte  = rst_n & mem_byte;
  assign ALUCtr   = rst_n ? alu_ctr : 3'b000;
  assign RegDst   = rst_n ? reg_dst : 2'b00;
  assign MemToReg = rst_n ? mem_to_reg : 2'b00;
  assign PCSrc    = rst_n ? pc_src : 2'b00;
endmodule

// File: doc/mips_mctrl.md
MIPS_MCTRL -- requirements
Module: mips_mctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have ports op input 6 and funct input 6, both from the instruction register, and rt input 5 for the REGIMM sub-code.
REQ-004 SHALL have ports zero, overflow and bltzal_sel, each input 1, the ALU status flags from the current cycle.
REQ-005 SHALL have port ALUCtr, output 3: 000 add, 001 subu, 010 or, 011 addi (trapping), 100 slt, 101 pass-b (lui).
REQ-006 SHALL have outputs PCWr, IRWr, RegWr, MemWr, ExtOp, each 1; MemByte 1 (lb/sb); ALUSrcB 1 (0 reg, 1 ext imm); RegDst 2 (00 rt, 01 rd, 10 $31); MemToReg 2 (00 ALU, 01 mem, 10 PC+4); PCSrc 2 (00 PC+4, 01 branch, 10 jump, 11 rs).
REQ-007 SHALL have output illegal, 1, a one-cycle pulse on an unsupported instruction.

Function
REQ-008 SHALL implement a Moore FSM; states FETCH, DCD, MA, MR, MWB, MW, EXE, AWB, BR, JMP; all outputs decode from state plus registered op/funct/rt, except PCWr in BR and RegWr in AWB.
REQ-009 FETCH: IRWr=1, PCWr=1, PCSrc=00; next is DCD unconditionally.
REQ-010 DCD: lw/lb/sw/sb go to MA; addu/subu/slt/ori/lui/addi/addiu go to EXE; beq and bltzal (op 000001, rt 10000) go to BR; j/jal/jr go to JMP; any other code pulses illegal and goes to FETCH.
REQ-011 MA: ALUCtr=000, ALUSrcB=1, ExtOp=1; loads go to MR, stores go to MW.
REQ-012 MR goes to MWB; MWB: RegWr=1, RegDst=00, MemToReg=01; next is FETCH.
REQ-013 MW: MemWr=1, MemByte=1 for sb; next is FETCH.
REQ-014 EXE: ALUCtr per instruction (addu/addiu 000, subu 001, ori 010, addi 011, slt 100, lui 101); ALUSrcB=0 for R-type, else 1; ExtOp=1 except ori; next is AWB.
REQ-015 AWB: ALUCtr held; RegWr=1 except for addi with overflow=1, where RegWr=0; RegDst=01 for R-type, else 00; next is FETCH.
REQ-016 BR: ALUCtr=001, ALUSrcB=0, PCSrc=01; PCWr=zero for beq and bltzal_sel for bltzal; for bltzal also RegWr=1, RegDst=10, MemToReg=10 whether or not the branch is taken; next is FETCH.
REQ-017 JMP: PCWr=1; PCSrc=11 for jr, else 10; jal asserts RegWr=1, RegDst=10, MemToReg=10; next is FETCH.
REQ-018 Any unlisted state encoding SHALL go to FETCH on the next edge with all write strobes at 0.
REQ-019 Latency in cycles: lw/lb 5; sw/sb 4; ALU ops 4; branch and jump 3.
REQ-020 op, funct and rt SHALL be registered in DCD, so later IR changes have no effect until the next DCD.

Reset
REQ-021 When rst_n=0 at a clock edge, the state SHALL be FETCH on the next cycle, overriding any transition.
REQ-022 While rst_n=0, PCWr, IRWr, RegWr, MemWr and illegal SHALL be 0, and ALUCtr, PCSrc, RegDst and MemToReg SHALL be 0.
REQ-023 Reset asserted mid-instruction SHALL discard that instruction with no register or memory write.

Structure
REQ-024 A shared package SHALL hold opcode and funct constants, the ALUCtr codes and the state encodings, so the ALU and the controller share the ALUCtr codes.
REQ-025 One sub-module SHALL exist, mips_idec: purely combinational, mapping op/funct/rt to an instruction-class one-hot and the EXE-state ALUCtr.

Verification
REQ-026 Scenario: lw (op 100011) -> FETCH, DCD, MA, MR, MWB; RegWr=1 with MemToReg=01 only in cycle 5.
REQ-027 Scenario: addi with overflow=1 in AWB -> RegWr=0; the same instruction with overflow=0 -> RegWr=1 and ALUCtr=011.
REQ-028 Scenario: beq with zero=1 -> PCWr=1 and PCSrc=01 in BR; with zero=0 -> PCWr=0 in BR.
REQ-029 Scenario: bltzal with bltzal_sel=0 -> PCWr=0 and RegWr=1 with RegDst=10; jal -> PCWr=1, PCSrc=10, RegWr=1.
REQ-030 Scenario: op 111111 -> illegal pulses one cycle in DCD, then FETCH, with no write strobes.
REQ-031 Scenario: rst_n=0 during MW -> MemWr=0 in that cycle; FETCH follows release.
